// File: rtl/ebus_burst_driver.sv
// ebus_burst_driver
//   Buffered EBUS transmit driver. Words from internal logic enter a small
//   FIFO through a valid/ready handshake. When the arbiter grants the bus the
//   block raises the pad enable for LEAD cycles, streams up to MAX_BURST words
//   back-to-back, then holds the pads off for TURN dead cycles before it can
//   request again. The tristate pad cells live at chip top.
//
// Parameters
//   WIDTH      EBUS data width
//   DEPTH      FIFO entries (power of 2, >= 2)
//   LEAD       enable-on cycles before the first word (0..7)
//   TURN       dead cycles after a burst (1..7)
//   MAX_BURST  max words per grant tenure (>= 1)
//
// Ports
//   clock          in   system clock, rising edge
//   reset_l        in   asynchronous active-low reset
//   in_data        in   word to transmit
//   in_valid       in   in_data valid
//   in_ready       out  FIFO can accept a word (not full)
//   bus_grant      in   arbiter grant (level, may drop any cycle)
//   bus_req        out  bus request (FIFO not empty, not in turnaround)
//   ebus_data_out  out  pad data: FIFO head while enabled, else 0
//   ebus_enable    out  pad output enable
//   ebus_valid     out  ebus_data_out carries a word this cycle
//   busy           out  FSM not idle or FIFO not empty
module ebus_burst_driver #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int LEAD      = 1,
  parameter int TURN      = 1,
  parameter int MAX_BURST = 8
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bus_grant,
  output logic             bus_req,
  output logic [WIDTH-1:0] ebus_data_out,
  output logic             ebus_enable,
  output logic             ebus_valid,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [2:0]    LEAD_LAST  = (LEAD > 0) ? 3'(LEAD - 1) : 3'd0;
  localparam logic [2:0]    TURN_LAST  = 3'(TURN - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_DRIVE,
    ST_TURN
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        lead_cnt_q, lead_cnt_d;
  logic [2:0]        turn_cnt_q, turn_cnt_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  head;
  logic [BW-1:0]     burst_next;

  // A push is refused whenever the FIFO is full, even if a pop frees a slot
  // in the same cycle, so in_ready depends on the count alone.
  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem_q[rd_ptr_q];
  assign pop      = (state_q == ST_DRIVE) && bus_grant && !empty;

  // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Burst state machine. A burst ends on grant loss, on the pop that drains
  // the FIFO, or on the MAX_BURST-th pop; the turnaround always runs in full.
  always_comb begin
    state_d     = state_q;
    lead_cnt_d  = lead_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    burst_cnt_d = burst_cnt_q;
    burst_next  = burst_cnt_q + BW'(1);
    case (state_q)
      ST_IDLE: begin
        if (bus_grant && !empty) begin
          lead_cnt_d  = '0;
          burst_cnt_d = '0;
          if (LEAD > 0) state_d = ST_LEAD;
          else          state_d = ST_DRIVE;
        end
      end
      ST_LEAD: begin
        if (!bus_grant) begin
          state_d    = ST_TURN;
          turn_cnt_d = '0;
        end else if (lead_cnt_q == LEAD_LAST) begin
          state_d = ST_DRIVE;
        end else begin
          lead_cnt_d = lead_cnt_q + 3'd1;
        end
      end
      ST_DRIVE: begin
        if (!bus_grant) begin
          state_d    = ST_TURN;
          turn_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_next;
          if ((count_q == CW'(1) && !push) || (burst_next == BURST_LAST)) begin
            state_d    = ST_TURN;
            turn_cnt_d = '0;
          end
        end
      end
      ST_TURN: begin
        if (turn_cnt_q == TURN_LAST) state_d = ST_IDLE;
        else                         turn_cnt_d = turn_cnt_q + 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad outputs are decoded from the state register only, so an async reset
  // drops the enable immediately.
  always_comb begin
    ebus_enable   = (state_q == ST_LEAD) || (state_q == ST_DRIVE);
    ebus_valid    = (state_q == ST_DRIVE);
    ebus_data_out = ebus_enable ? head : '0;
    bus_req       = !empty && (state_q != ST_TURN);
    busy          = (state_q != ST_IDLE) || !empty;
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= ST_IDLE;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lead_cnt_q  <= '0;
      turn_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lead_cnt_q  <= lead_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_ebus_burst_driver.sv
// tb_ebus_burst_driver
//   Bench for ebus_burst_driver (DEPTH=4, LEAD=1, TURN=1, MAX_BURST=2).
//   Accepted words are queued as expectations; a negedge monitor pops and
//   compares each word the DUT hands over (valid with grant held).
module tb_ebus_burst_driver;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int LEAD      = 1;
  localparam int TURN      = 1;
  localparam int MAX_BURST = 2;

  logic             clock = 1'b0;
  logic             reset_l = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             bus_grant = 1'b0;
  logic             bus_req;
  logic [WIDTH-1:0] ebus_data_out;
  logic             ebus_enable;
  logic             ebus_valid;
  logic             busy;

  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  bit               record_pops = 1'b0;
  bit               prod_done = 1'b0;
  logic [WIDTH-1:0] exp_q[$];
  int               pop_cycles[$];
  logic [WIDTH-1:0] exp_word;
  int               exp_delta[5] = '{0, 1, 5, 6, 10};

  ebus_burst_driver #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LEAD(LEAD), .TURN(TURN), .MAX_BURST(MAX_BURST)
  ) dut (
    .clock        (clock),
    .reset_l      (reset_l),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bus_grant    (bus_grant),
    .bus_req      (bus_req),
    .ebus_data_out(ebus_data_out),
    .ebus_enable  (ebus_enable),
    .ebus_valid   (ebus_valid),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one word and hold it until the FIFO takes it; the expectation is
  // queued at the moment the handshake completes.
  task automatic applyStimulus(input logic [WIDTH-1:0] data);
    bit ok;
    ok       = 1'b0;
    in_data  = data;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (in_ready) begin
        exp_q.push_back(data);
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) checkOutput("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput(name, 32'(busy), 32'(0));
  endtask

  task automatic wait_valid(input string name);
    for (int n = 0; n < 30 && !ebus_valid; n++) tick();
    checkOutput(name, 32'(ebus_valid), 32'(1));
  endtask

  // Scoreboard monitor: a word is consumed when valid is presented with grant.
  always @(negedge clock) begin
    if (!reset_l) begin
      exp_q.delete();
    end else begin
      if (ebus_valid) checkOutput("valid_needs_enable", 32'(ebus_enable), 32'(1));
      if (ebus_valid && bus_grant) begin
        if (record_pops) pop_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_word", 32'(ebus_data_out), 32'hFFFF_FFFF);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput("sb_word", 32'(ebus_data_out), 32'(exp_word));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
    checkOutput("rst_bus_req", 32'(bus_req), 32'(0));
    checkOutput("rst_data", 32'(ebus_data_out), 32'(0));
    checkOutput("rst_enable", 32'(ebus_enable), 32'(0));
    checkOutput("rst_valid", 32'(ebus_valid), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    tick();
    reset_l = 1'b1;
    tick();

    // Single word under continuous grant: enable at cycles 2-3, valid at 3
    $display("[TB] single word");
    bus_grant = 1'b1;
    applyStimulus(8'hA5);
    checkOutput("t2_c1_enable", 32'(ebus_enable), 32'(0));
    checkOutput("t2_c1_busy", 32'(busy), 32'(1));
    checkOutput("t2_c1_req", 32'(bus_req), 32'(1));
    tick();
    checkOutput("t2_c2_enable", 32'(ebus_enable), 32'(1));
    checkOutput("t2_c2_valid", 32'(ebus_valid), 32'(0));
    checkOutput("t2_c2_data", 32'(ebus_data_out), 32'hA5);
    tick();
    checkOutput("t2_c3_valid", 32'(ebus_valid), 32'(1));
    checkOutput("t2_c3_data", 32'(ebus_data_out), 32'hA5);
    tick();
    checkOutput("t2_c4_enable", 32'(ebus_enable), 32'(0));
    checkOutput("t2_c4_data", 32'(ebus_data_out), 32'(0));
    checkOutput("t2_c4_busy", 32'(busy), 32'(1));
    tick();
    checkOutput("t2_c5_busy", 32'(busy), 32'(0));
    bus_grant = 1'b0;

    // Full FIFO: fifth word refused until the first pop
    $display("[TB] full fifo");
    for (int i = 0; i < 4; i++) applyStimulus(8'h30 + 8'(i));
    checkOutput("t3_full_ready", 32'(in_ready), 32'(0));
    checkOutput("t3_full_req", 32'(bus_req), 32'(1));
    checkOutput("t3_no_grant_enable", 32'(ebus_enable), 32'(0));
    in_data  = 8'h34;
    in_valid = 1'b1;
    tick();
    tick();
    checkOutput("t3_still_refused", 32'(in_ready), 32'(0));
    in_valid  = 1'b0;
    bus_grant = 1'b1;
    applyStimulus(8'h34);
    wait_idle("t3_drain_timeout");
    bus_grant = 1'b0;

    // Burst cap: pops land at relative cycles 0,1 | 5,6 | 10
    $display("[TB] burst cap");
    pop_cycles.delete();
    record_pops = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(8'h40 + 8'(i));
    bus_grant = 1'b1;
    applyStimulus(8'h44);
    wait_idle("t4_drain_timeout");
    record_pops = 1'b0;
    bus_grant   = 1'b0;
    checkOutput("t4_pop_count", 32'(pop_cycles.size()), 32'(5));
    if (pop_cycles.size() == 5) begin
      for (int i = 0; i < 5; i++)
        checkOutput($sformatf("t4_pop_delta%0d", i),
                    32'(pop_cycles[i] - pop_cycles[0]), 32'(exp_delta[i]));
    end

    // Grant loss on the second DRIVE cycle
    $display("[TB] grant loss");
    for (int i = 0; i < 3; i++) applyStimulus(8'h50 + 8'(i));
    bus_grant = 1'b1;
    wait_valid("t5_reach_drive");
    checkOutput("t5_d1_data", 32'(ebus_data_out), 32'h50);
    tick();
    checkOutput("t5_d2_data", 32'(ebus_data_out), 32'h51);
    bus_grant = 1'b0;
    tick();
    checkOutput("t5_enable_drop", 32'(ebus_enable), 32'(0));
    checkOutput("t5_busy", 32'(busy), 32'(1));
    bus_grant = 1'b1;
    wait_idle("t5_drain_timeout");
    bus_grant = 1'b0;

    // Pointer wrap with random grant and valid gaps
    $display("[TB] wrap stream");
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 3 * DEPTH + 1; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          applyStimulus(8'h60 + 8'(i * 7));
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          bus_grant = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    bus_grant = 1'b1;
    wait_idle("t6_drain_timeout");
    bus_grant = 1'b0;
    checkOutput("t6_all_words_seen", 32'(exp_q.size()), 32'(0));

    // Asynchronous reset in the middle of a burst
    $display("[TB] reset mid-drive");
    for (int i = 0; i < 3; i++) applyStimulus(8'h70 + 8'(i));
    bus_grant = 1'b1;
    wait_valid("t1_reach_drive");
    #2;
    reset_l = 1'b0;
    #1;
    checkOutput("t1_enable", 32'(ebus_enable), 32'(0));
    checkOutput("t1_valid", 32'(ebus_valid), 32'(0));
    checkOutput("t1_data", 32'(ebus_data_out), 32'(0));
    checkOutput("t1_in_ready", 32'(in_ready), 32'(1));
    checkOutput("t1_busy", 32'(busy), 32'(0));
    checkOutput("t1_bus_req", 32'(bus_req), 32'(0));
    tick();
    bus_grant = 1'b0;
    reset_l   = 1'b1;
    tick();
    checkOutput("t1_idle_after_release", 32'(busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
